// File: rtl/spi_axil_ctrl_if.sv
// AXI4-Lite slave-side bus bundle for the SPI control register block.
interface spi_axil_ctrl_if #(
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] S_AWADDR;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [31:0]       S_WDATA;
  logic [3:0]        S_WSTRB;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic [ADDR_W-1:0] S_ARADDR;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [31:0]       S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY;

  modport master (
    output S_AWADDR, S_AWVALID, input S_AWREADY,
    output S_WDATA, S_WSTRB, S_WVALID, input S_WREADY,
    input S_BRESP, S_BVALID, output S_BREADY,
    output S_ARADDR, S_ARVALID, input S_ARREADY,
    input S_RDATA, S_RRESP, S_RVALID, output S_RREADY
  );

  modport slave (
    input S_AWADDR, S_AWVALID, output S_AWREADY,
    input S_WDATA, S_WSTRB, S_WVALID, output S_WREADY,
    output S_BRESP, S_BVALID, input S_BREADY,
    input S_ARADDR, S_ARVALID, output S_ARREADY,
    output S_RDATA, S_RRESP, S_RVALID, input S_RREADY
  );
endinterface

// File: rtl/spi_axil_ctrl.sv
// AXI4-Lite register block in front of the SPI master: config/timing registers,
// one-frame-per-TXDATA-write sequencer and a single-entry RX capture register.
module spi_axil_ctrl #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic           GCLK,
  input  logic           RST_N,
  spi_axil_ctrl_if.slave s_axil,
  output logic [1:0]     spi_mode,
  output logic [1:0]     sck_speed,
  output logic [1:0]     word_len,
  output logic [7:0]     t_IFG,
  output logic [7:0]     t_CS_SCK,
  output logic [7:0]     t_SCK_CS,
  output logic           start,
  output logic [31:0]    mosi_data,
  input  logic           spi_busy,
  input  logic [31:0]    miso_data
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StCapture} seq_state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  localparam logic [2:0] IdxCtrl   = 3'd0;
  localparam logic [2:0] IdxTiming = 3'd1;
  localparam logic [2:0] IdxTx     = 3'd2;
  localparam logic [2:0] IdxRx     = 3'd3;
  localparam logic [2:0] IdxStatus = 3'd4;

  seq_state_e  state_q, state_d;
  logic        aw_held_q, aw_held_d;
  logic [2:0]  aw_idx_q, aw_idx_d;
  logic        w_held_q, w_held_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic [23:0] timing_q, timing_d;
  logic [31:0] mosi_q, mosi_d;
  logic        start_q, start_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;

  logic [ADDR_W-1:0] awaddr, araddr;
  logic        seq_busy;
  logic        aw_ready, w_ready, ar_ready;
  logic        aw_hs, w_hs, ar_hs;
  logic        wr_exec;
  logic [23:0] wmask;
  logic        tx_launch, rx_rd, ovr_clr;
  logic        unused_bits;

  assign awaddr   = s_axil.S_AWADDR;
  assign araddr   = s_axil.S_ARADDR;
  assign seq_busy = (state_q != StIdle);
  assign aw_ready = !aw_held_q && !bvalid_q;
  assign w_ready  = !w_held_q && !bvalid_q;
  assign ar_ready = !rvalid_q;
  assign aw_hs    = s_axil.S_AWVALID && aw_ready;
  assign w_hs     = s_axil.S_WVALID && w_ready;
  assign ar_hs    = s_axil.S_ARVALID && ar_ready;
  assign wr_exec  = aw_held_q && w_held_q && !bvalid_q;
  // Only the low three strobes matter: no writable field reaches byte 3.
  assign wmask    = {{8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign unused_bits = ^{awaddr[1:0], araddr[1:0], s_axil.S_WSTRB[3]};

  assign s_axil.S_AWREADY = aw_ready;
  assign s_axil.S_WREADY  = w_ready;
  assign s_axil.S_BVALID  = bvalid_q;
  assign s_axil.S_BRESP   = bresp_q;
  assign s_axil.S_ARREADY = ar_ready;
  assign s_axil.S_RVALID  = rvalid_q;
  assign s_axil.S_RDATA   = rdata_q;
  assign s_axil.S_RRESP   = rresp_q;

  assign spi_mode  = ctrl_q[1:0];
  assign sck_speed = ctrl_q[3:2];
  assign word_len  = ctrl_q[5:4];
  assign t_IFG     = timing_q[7:0];
  assign t_CS_SCK  = timing_q[15:8];
  assign t_SCK_CS  = timing_q[23:16];
  assign start     = start_q;
  assign mosi_data = mosi_q;

  // Write channel: latch AW/W independently, execute once both are held.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    timing_d  = timing_q;
    tx_launch = 1'b0;
    ovr_clr   = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = awaddr[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil.S_WDATA;
      wstrb_d  = s_axil.S_WSTRB[2:0];
    end
    if (bvalid_q && s_axil.S_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (wr_exec) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RespOkay;
      case (aw_idx_q)
        IdxCtrl: begin
          if (seq_busy) bresp_d = RespSlvErr;
          else ctrl_d = (ctrl_q & ~wmask[5:0]) | (wdata_q[5:0] & wmask[5:0]);
        end
        IdxTiming: begin
          if (seq_busy) bresp_d = RespSlvErr;
          else timing_d = (timing_q & ~wmask) | (wdata_q[23:0] & wmask);
        end
        IdxTx: begin
          if (seq_busy) bresp_d = RespSlvErr;
          else tx_launch = 1'b1;
        end
        IdxRx:     bresp_d = RespSlvErr;
        IdxStatus: ovr_clr = wdata_q[2] && wstrb_q[0];
        default:   bresp_d = RespDecErr;
      endcase
    end
  end

  // Read channel: register data/response on the AR handshake, hold until RREADY.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rx_rd    = 1'b0;
    if (rvalid_q && s_axil.S_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RespOkay;
      rdata_d  = '0;
      case (araddr[4:2])
        IdxCtrl:   rdata_d = {26'd0, ctrl_q};
        IdxTiming: rdata_d = {8'd0, timing_q};
        IdxTx:     rdata_d = '0;
        IdxRx: begin
          rdata_d = rx_data_q;
          rx_rd   = 1'b1;
        end
        IdxStatus: rdata_d = {29'd0, rx_overrun_q, rx_valid_q, seq_busy};
        default:   rresp_d = RespDecErr;
      endcase
    end
  end

  // Frame sequencer; capture is evaluated last so it beats a same-cycle read or W1C.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    mosi_d       = mosi_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    if (rx_rd) rx_valid_d = 1'b0;
    if (ovr_clr) rx_overrun_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (tx_launch) begin
          mosi_d  = wdata_q;
          start_d = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: if (spi_busy) state_d = StWait;
      StWait:   if (!spi_busy) state_d = StCapture;
      StCapture: begin
        rx_data_d  = miso_data;
        rx_valid_d = 1'b1;
        if (rx_valid_q) rx_overrun_d = 1'b1;
        start_d    = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; asynchronous reset drops start without waiting for a clock.
  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      aw_held_q    <= 1'b0;
      aw_idx_q     <= '0;
      w_held_q     <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RespOkay;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RespOkay;
      ctrl_q       <= '0;
      timing_q     <= 24'h020204;
      mosi_q       <= '0;
      start_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      aw_held_q    <= aw_held_d;
      aw_idx_q     <= aw_idx_d;
      w_held_q     <= w_held_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      ctrl_q       <= ctrl_d;
      timing_q     <= timing_d;
      mosi_q       <= mosi_d;
      start_q      <= start_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_axil_ctrl.sv
// Scoreboard bench for spi_axil_ctrl with a cycle-counted SPI master model.
module tb_spi_axil_ctrl;

  localparam logic [1:0] Okay   = 2'b00;
  localparam logic [1:0] SlvErr = 2'b10;
  localparam logic [1:0] DecErr = 2'b11;

  logic GCLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 GCLK = ~GCLK;

  spi_axil_ctrl_if #(.ADDR_W(5)) axil ();

  logic [1:0]  spi_mode, sck_speed, word_len;
  logic [7:0]  t_IFG, t_CS_SCK, t_SCK_CS;
  logic        start;
  logic [31:0] mosi_data;
  logic        spi_busy = 1'b0;
  logic [31:0] miso_data = '0;

  spi_axil_ctrl #(.ADDR_W(5)) dut (
    .GCLK      (GCLK),
    .RST_N     (RST_N),
    .s_axil    (axil.slave),
    .spi_mode  (spi_mode),
    .sck_speed (sck_speed),
    .word_len  (word_len),
    .t_IFG     (t_IFG),
    .t_CS_SCK  (t_CS_SCK),
    .t_SCK_CS  (t_SCK_CS),
    .start     (start),
    .mosi_data (mosi_data),
    .spi_busy  (spi_busy),
    .miso_data (miso_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [33:0] v;
  } exp_t;
  exp_t bq[$];
  exp_t rq[$];

  function automatic void chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // SPI master model: busy rises 3 cycles after start, falls 40 cycles later.
  localparam int BusyOn  = 2;
  localparam int BusyOff = 42;
  localparam int Done    = 1000;
  int          m_cyc = 0;
  logic [1:0]  m_idx = 2'd0;
  logic [31:0] m_words [4] = '{32'h1234_5678, 32'hCAFE_0001, 32'hCAFE_0002, 32'hBEEF_0077};

  always @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      m_cyc    <= 0;
      spi_busy <= 1'b0;
    end else if (m_cyc == 0) begin
      if (start) m_cyc <= 1;
    end else if (m_cyc == BusyOn) begin
      spi_busy <= 1'b1;
      m_cyc    <= m_cyc + 1;
    end else if (m_cyc == BusyOff) begin
      spi_busy  <= 1'b0;
      miso_data <= m_words[m_idx];
      m_idx     <= m_idx + 2'd1;
      m_cyc     <= Done;
    end else if (m_cyc == Done) begin
      if (!start) m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  // Response monitors: pop the expected value whenever a response is presented.
  always @(negedge GCLK) begin
    if (axil.S_BVALID && axil.S_BREADY) begin
      if (bq.size() == 0) timeout("unexpected_bresp");
      else begin
        exp_t e;
        e = bq.pop_front();
        chk(e.name, {32'd0, axil.S_BRESP}, e.v);
      end
    end
    if (axil.S_RVALID && axil.S_RREADY) begin
      if (rq.size() == 0) timeout("unexpected_rdata");
      else begin
        exp_t e;
        e = rq.pop_front();
        chk(e.name, {axil.S_RRESP, axil.S_RDATA}, e.v);
      end
    end
  end

  task automatic aw_send(input logic [4:0] a);
    int n = 0;
    @(negedge GCLK);
    axil.S_AWADDR  = a;
    axil.S_AWVALID = 1'b1;
    while (!axil.S_AWREADY && n < 50) begin
      @(negedge GCLK);
      n++;
    end
    if (n >= 50) timeout("awready");
    @(posedge GCLK);
    #1 axil.S_AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge GCLK);
    axil.S_WDATA  = d;
    axil.S_WSTRB  = s;
    axil.S_WVALID = 1'b1;
    while (!axil.S_WREADY && n < 50) begin
      @(negedge GCLK);
      n++;
    end
    if (n >= 50) timeout("wready");
    @(posedge GCLK);
    #1 axil.S_WVALID = 1'b0;
  endtask

  task automatic axi_write(input string name, input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er, input int w_delay = 0);
    exp_t e;
    int n = 0;
    e.name = name;
    e.v    = {32'd0, er};
    bq.push_back(e);
    fork
      aw_send(a);
      begin
        repeat (w_delay) @(negedge GCLK);
        w_send(d, s);
      end
    join
    while (!axil.S_BVALID && n < 20) begin
      @(negedge GCLK);
      n++;
    end
    if (n >= 20) timeout({name, "_bvalid"});
  endtask

  task automatic axi_read(input string name, input logic [4:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
    exp_t e;
    int n = 0;
    e.name = name;
    e.v    = {er, ed};
    rq.push_back(e);
    @(negedge GCLK);
    axil.S_ARADDR  = a;
    axil.S_ARVALID = 1'b1;
    while (!axil.S_ARREADY && n < 50) begin
      @(negedge GCLK);
      n++;
    end
    if (n >= 50) timeout("arready");
    @(posedge GCLK);
    #1 axil.S_ARVALID = 1'b0;
    n = 0;
    while (!axil.S_RVALID && n < 20) begin
      @(negedge GCLK);
      n++;
    end
    if (n >= 20) timeout({name, "_rvalid"});
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (start && n < 200) begin
      @(negedge GCLK);
      n++;
    end
    if (n >= 200) timeout(name);
    @(negedge GCLK);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start_cycles;
    axil.S_AWADDR  = '0;
    axil.S_AWVALID = 1'b0;
    axil.S_WDATA   = '0;
    axil.S_WSTRB   = '0;
    axil.S_WVALID  = 1'b0;
    axil.S_BREADY  = 1'b1;
    axil.S_ARADDR  = '0;
    axil.S_ARVALID = 1'b0;
    axil.S_RREADY  = 1'b1;
    repeat (3) @(negedge GCLK);
    RST_N = 1'b1;
    @(negedge GCLK);

    // Reset state.
    chk("ready_after_reset", {31'd0, axil.S_AWREADY & axil.S_WREADY & axil.S_ARREADY}, 34'd1);
    chk("valids_after_reset", {32'd0, axil.S_BVALID, axil.S_RVALID}, 34'd0);
    chk("timing_outputs_reset", {10'd0, t_SCK_CS, t_CS_SCK, t_IFG}, 34'h020204);
    chk("start_mosi_reset", {1'b0, start, mosi_data}, 34'd0);
    axi_read("rd_ctrl_reset", 5'h00, 32'h0, Okay);
    axi_read("rd_timing_reset", 5'h04, 32'h0002_0204, Okay);
    axi_read("rd_txdata_zero", 5'h08, 32'h0, Okay);
    axi_read("rd_rxdata_reset", 5'h0C, 32'h0, Okay);
    axi_read("rd_status_reset", 5'h10, 32'h0, Okay);
    axi_read("rd_0x14_decerr", 5'h14, 32'h0, DecErr);
    axi_read("rd_0x1c_decerr", 5'h1C, 32'h0, DecErr);

    // CTRL via byte 0 only, AW leading W by two cycles.
    axi_write("wr_ctrl_aw_first", 5'h00, 32'hFFFF_FF3D, 4'h1, Okay, 2);
    chk("ctrl_fields", {28'd0, spi_mode, sck_speed, word_len}, {28'd0, 2'd1, 2'd3, 2'd3});
    axi_write("wr_ctrl_nostrb", 5'h00, 32'h0000_00FF, 4'h0, Okay);
    axi_read("rd_ctrl_kept", 5'h00, 32'h0000_003D, Okay);
    axi_write("wr_timing_byte1", 5'h04, 32'h0000_1100, 4'h2, Okay);
    chk("timing_byte1", {26'd0, t_CS_SCK}, 34'h11);
    axi_read("rd_timing_byte1", 5'h04, 32'h0002_1104, Okay);
    axi_write("wr_decerr", 5'h14, 32'h1, 4'hF, DecErr);

    // Frame 1; WSTRB=0 must not matter for TXDATA.
    axi_write("wr_tx_frame1", 5'h08, 32'hA5A5_0F0F, 4'h0, Okay);
    chk("start_on_launch", {33'd0, start}, 34'd1);
    chk("mosi_on_launch", {2'd0, mosi_data}, {2'd0, 32'hA5A5_0F0F});
    fork
      begin
        start_cycles = 0;
        while (start && start_cycles < 200) begin
          start_cycles++;
          @(negedge GCLK);
        end
      end
      begin
        axi_write("wr_timing_busy", 5'h04, 32'hFFFF_FFFF, 4'hF, SlvErr);
        axi_write("wr_tx_busy", 5'h08, 32'h0000_DEAD, 4'hF, SlvErr);
        axi_write("wr_ctrl_busy", 5'h00, 32'h0, 4'hF, SlvErr);
        axi_write("wr_rxdata", 5'h0C, 32'h0, 4'hF, SlvErr);
        axi_read("rd_timing_unchanged", 5'h04, 32'h0002_1104, Okay);
        chk("timing_out_stable", {26'd0, t_CS_SCK}, 34'h11);
      end
    join
    // 3 launch cycles before busy, 40 busy, 1 WAIT cycle seeing busy low, 1 CAPTURE.
    chk("start_high_cycles", 34'(start_cycles), 34'd45);
    chk("mosi_held", {2'd0, mosi_data}, {2'd0, 32'hA5A5_0F0F});
    @(negedge GCLK);
    axi_read("rd_status_rxvalid", 5'h10, 32'h2, Okay);
    axi_read("rd_rxdata_frame1", 5'h0C, 32'h1234_5678, Okay);
    axi_read("rd_status_cleared", 5'h10, 32'h0, Okay);

    // Two frames without reading RXDATA -> overrun.
    axi_write("wr_tx_frame2", 5'h08, 32'h0000_0011, 4'hF, Okay);
    wait_frame("frame2_end");
    axi_write("wr_tx_frame3", 5'h08, 32'h0000_0022, 4'hF, Okay);
    chk("mosi_frame3", {2'd0, mosi_data}, 34'h22);
    wait_frame("frame3_end");
    axi_read("rd_status_overrun", 5'h10, 32'h6, Okay);
    axi_write("wr_status_w1c", 5'h10, 32'h4, 4'h1, Okay);
    axi_read("rd_status_after_w1c", 5'h10, 32'h2, Okay);
    axi_read("rd_rxdata_frame3", 5'h0C, 32'hCAFE_0002, Okay);
    axi_read("rd_status_idle", 5'h10, 32'h0, Okay);

    // Reset while the sequencer is waiting on a busy master.
    axi_write("wr_tx_abort", 5'h08, 32'h0000_0055, 4'hF, Okay);
    begin
      int n = 0;
      while (!spi_busy && n < 20) begin
        @(negedge GCLK);
        n++;
      end
      if (n >= 20) timeout("busy_before_reset");
    end
    repeat (3) @(negedge GCLK);
    chk("start_before_reset", {33'd0, start}, 34'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("start_async_drop", {33'd0, start}, 34'd0);
    chk("mosi_async_clear", {2'd0, mosi_data}, 34'd0);
    @(negedge GCLK);
    RST_N = 1'b1;
    @(negedge GCLK);
    axi_read("rd_ctrl_after_reset", 5'h00, 32'h0, Okay);
    axi_read("rd_status_after_reset", 5'h10, 32'h0, Okay);
    axi_write("wr_tx_after_reset", 5'h08, 32'h0000_0077, 4'hF, Okay);
    chk("start_after_reset", {33'd0, start}, 34'd1);
    wait_frame("frame4_end");
    axi_read("rd_rxdata_frame4", 5'h0C, 32'hBEEF_0077, Okay);

    repeat (2) @(negedge GCLK);
    chk("scoreboard_drained", 34'(bq.size() + rq.size()), 34'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
